// File: rtl/fifobuf_param.sv
// rtl/fifobuf_param.sv - parametrised synchronous FIFO with level, almost flags and sticky errors
// Optional first-word-fall-through read mode: define FIFOBUF_FWFT_EN.
module fifobuf_param #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int AFULL_TH  = 2**ADDR_W-2,
    parameter int AEMPTY_TH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wren,
    input  logic [DATA_W-1:0] idata,
    input  logic              rden,
    input  logic              err_clr,
    output logic              iready,
    output logic [DATA_W-1:0] odata,
    output logic              oready,
    output logic [ADDR_W:0]   level,
    output logic              afull,
    output logic              aempty,
    output logic              ovf,
    output logic              udf,
    output logic              err
);
    localparam int              DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W:0] LP_DEPTH  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LP_AFULL  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] LP_AEMPTY = (ADDR_W+1)'(AEMPTY_TH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_level;
    logic [DATA_W-1:0] r_odata;
    logic              r_ovf;
    logic              r_udf;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_ovf_ev;
    logic w_udf_ev;

    assign w_full   = (r_level == LP_DEPTH);
    assign w_empty  = (r_level == '0);
    assign w_wr_acc = wren & ~w_full;
    assign w_ovf_ev = wren & w_full;

    always_ff @(posedge clk) begin
        if (!reset && w_wr_acc) begin
            r_mem[r_wptr] <= idata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
        end else if (w_wr_acc) begin
            r_wptr <= r_wptr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_level <= r_level + (ADDR_W+1)'(1);
                2'b01:   r_level <= r_level - (ADDR_W+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef FIFOBUF_FWFT_EN
    // Two-stage prefetch: RAM read register, then the visible output stage.
    logic              r_pf_valid;
    logic [DATA_W-1:0] r_pf_data;
    logic              r_oval;
    logic [ADDR_W:0]   w_ram_cnt;
    logic              w_stage_adv;
    logic              w_pf_rd;

    assign w_rd_acc    = rden & r_oval;
    assign w_udf_ev    = rden & ~r_oval;
    assign w_ram_cnt   = r_level - {{ADDR_W{1'b0}}, r_oval} - {{ADDR_W{1'b0}}, r_pf_valid};
    assign w_stage_adv = ~r_oval | w_rd_acc;
    assign w_pf_rd     = (w_ram_cnt != '0) & (~r_pf_valid | w_stage_adv);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rptr     <= '0;
            r_pf_valid <= 1'b0;
            r_pf_data  <= '0;
            r_oval     <= 1'b0;
            r_odata    <= '0;
        end else begin
            if (w_pf_rd) begin
                r_pf_data <= r_mem[r_rptr];
                r_rptr    <= r_rptr + ADDR_W'(1);
            end
            if (w_pf_rd) begin
                r_pf_valid <= 1'b1;
            end else if (w_stage_adv) begin
                r_pf_valid <= 1'b0;
            end
            if (w_stage_adv) begin
                r_oval <= r_pf_valid;
                if (r_pf_valid) begin
                    r_odata <= r_pf_data;
                end
            end
        end
    end

    assign oready = r_oval;
`else
    assign w_rd_acc = rden & ~w_empty;
    assign w_udf_ev = rden & w_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rptr  <= '0;
            r_odata <= '0;
        end else if (w_rd_acc) begin
            r_odata <= r_mem[r_rptr];
            r_rptr  <= r_rptr + ADDR_W'(1);
        end
    end

    assign oready = ~w_empty;
`endif

    // A same-cycle event wins over err_clr.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= (r_ovf & ~err_clr) | w_ovf_ev;
            r_udf <= (r_udf & ~err_clr) | w_udf_ev;
        end
    end

    assign iready = ~w_full;
    assign odata  = r_odata;
    assign level  = r_level;
    assign afull  = (r_level >= LP_AFULL);
    assign aempty = (r_level <= LP_AEMPTY);
    assign ovf    = r_ovf;
    assign udf    = r_udf;
    assign err    = r_ovf | r_udf;
endmodule

// File: tb/tb_fifobuf_param.sv
// tb/tb_fifobuf_param.sv - scoreboard bench for fifobuf_param (ADDR_W=4, DATA_W=8)
module tb_fifobuf_param;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wren = 1'b0;
    logic [7:0] idata = '0;
    logic       rden = 1'b0;
    logic       err_clr = 1'b0;
    logic       iready;
    logic [7:0] odata;
    logic       oready;
    logic [4:0] level;
    logic       afull;
    logic       aempty;
    logic       ovf;
    logic       udf;
    logic       err;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb [$];
    logic       fire = 1'b0;

    fifobuf_param #(.ADDR_W(4), .DATA_W(8), .AFULL_TH(14), .AEMPTY_TH(2)) dut (
        .clk(clk), .reset(reset), .wren(wren), .idata(idata), .rden(rden),
        .err_clr(err_clr), .iready(iready), .odata(odata), .oready(oready),
        .level(level), .afull(afull), .aempty(aempty), .ovf(ovf), .udf(udf),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_cmp();
        logic [7:0] e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underrun: got %0h expected none", odata);
        end else begin
            e = sb.pop_front();
            chk("odata_sb", odata, e);
        end
    endtask

`ifdef FIFOBUF_FWFT_EN
    always @(negedge clk) begin
        if (rden && oready && !reset) pop_cmp();
    end
`else
    always @(posedge clk) fire <= rden && oready && !reset;
    always @(negedge clk) begin
        if (fire) pop_cmp();
    end
`endif

    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
        wren = w; idata = d; rden = r; err_clr = c;
        @(posedge clk); #1;
        wren = 1'b0; rden = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        do_reset();
        chk("rst_level", level, 0);
        chk("rst_iready", iready, 1);
        chk("rst_oready", oready, 0);
        chk("rst_afull", afull, 0);
        chk("rst_aempty", aempty, 1);
        chk("rst_err", err, 0);
        chk("rst_odata", odata, 8'h00);

`ifdef FIFOBUF_FWFT_EN
        cyc(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("fwft_lat_n", oready, 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("fwft_lat_n1", oready, 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("fwft_lat_n2", oready, 1);
        chk("fwft_odata", odata, 8'h5A);
        chk("fwft_level1", level, 1);
        sb.push_back(8'h5A);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fwft_pop_empty", oready, 0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("fwft_level8", level, 8);
        for (int i = 0; i < 8; i++) begin
            chk("fwft_no_bubble", oready, 1);
            sb.push_back(8'hC0 + 8'(i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("fwft_drained", level, 0);
        chk("fwft_oready0", oready, 0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fwft_udf", udf, 1);
`else
        // basic write/read
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        cyc(1'b1, 8'h33, 1'b0, 1'b0);
        chk("basic_level3", level, 3);
        sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("basic_level0", level, 0);
        chk("basic_oready", oready, 0);
        chk("basic_err", err, 0);

        // fill, afull, overflow, drain
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
            chk("fill_afull", afull, (i + 1 >= 14) ? 1 : 0);
            chk("fill_aempty", aempty, (i + 1 <= 2) ? 1 : 0);
        end
        chk("full_iready", iready, 0);
        chk("full_level", level, 16);
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_set", ovf, 1);
        chk("ovf_err", err, 1);
        chk("ovf_level", level, 16);
        for (int i = 0; i < 16; i++) begin
            sb.push_back(8'(i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain_level", level, 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", ovf, 0);

        // underflow after reset
        do_reset();
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("udf_set", udf, 1);
        chk("udf_odata", odata, 8'h00);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("udf_clr", udf, 0);
        chk("udf_clr_err", err, 0);

        // simultaneous write/read when full and when empty
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
        sb.push_back(8'h40);
        cyc(1'b1, 8'hBB, 1'b1, 1'b0);
        chk("fullboth_ovf", ovf, 1);
        chk("fullboth_level", level, 15);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 1; i < 16; i++) begin
            sb.push_back(8'h40 + 8'(i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("fullboth_drained", level, 0);
        cyc(1'b1, 8'hCC, 1'b1, 1'b0);
        chk("emptyboth_level", level, 1);
        chk("emptyboth_udf", udf, 1);
        sb.push_back(8'hCC);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("emptyboth_drain", level, 0);

        // pointer wrap
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
            sb.push_back(8'h80 + 8'(i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            if (level > 16) chk("wrap_level_bound", level, 16);
        end
        chk("wrap_level", level, 0);

        // reset mid-operation, with requests in the reset cycle
        for (int i = 0; i < 9; i++) cyc(1'b1, 8'h90 + 8'(i), 1'b0, 1'b0);
        chk("pre_rst_level", level, 9);
        reset = 1'b1;
        cyc(1'b1, 8'hEE, 1'b1, 1'b0);
        reset = 1'b0;
        chk("midrst_level", level, 0);
        chk("midrst_oready", oready, 0);
        chk("midrst_odata", odata, 8'h00);
        chk("midrst_err", err, 0);
`endif
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("sb_leftover", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
